// File: rtl/minialu_exec_stage.sv
// MiniAlu execute stage: captures one decoded instruction per clock, forwards the
// last write-back, executes it, and drives RAM write-back, LED and fetch redirect.
module minialu_exec_stage #(
  parameter int DATA_W    = 16,
  parameter int IP_W      = 16,
  parameter int REG_AW    = 8,
  parameter int RAS_DEPTH = 4,
  parameter int LED_W     = 8
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             iValid,
  input  logic [3:0]                       iOperation,
  input  logic [REG_AW-1:0]                iDestination,
  input  logic [REG_AW-1:0]                iSourceAddr0,
  input  logic [REG_AW-1:0]                iSourceAddr1,
  input  logic [IP_W-1:0]                  iReturnIP,
  input  logic [DATA_W-1:0]                iSourceData0_RAM,
  input  logic [DATA_W-1:0]                iSourceData1_RAM,
  output logic                             oWriteEnable,
  output logic [REG_AW-1:0]                oWriteAddress,
  output logic [DATA_W-1:0]                oWriteData,
  output logic                             oBranchTaken,
  output logic [IP_W-1:0]                  oBranchTarget,
  output logic [LED_W-1:0]                 oLed,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   oStackDepth,
  output logic                             oStackOverflow,
  output logic                             oStackUnderflow
);

  localparam int SP_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_BLE  = 4'h6;
  localparam logic [3:0] OP_LED  = 4'h7;
  localparam logic [3:0] OP_CALL = 4'h8;
  localparam logic [3:0] OP_RET  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_STO  = 4'hC;

  logic              r_valid;
  logic [3:0]        r_op;
  logic [REG_AW-1:0] r_dst;
  logic [REG_AW-1:0] r_a0;
  logic [REG_AW-1:0] r_a1;
  logic [IP_W-1:0]   r_ret_ip;
  logic              r_squash;

  logic              r_prev_valid;
  logic [REG_AW-1:0] r_prev_addr;
  logic [DATA_W-1:0] r_prev_data;

  logic [IP_W-1:0]    r_ras [RAS_DEPTH];
  logic [SP_W-1:0]    r_sp;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_ovf;
  logic               r_unf;
  logic [LED_W-1:0]   r_led;

  logic              w_active;
  logic              w_fwd0;
  logic              w_fwd1;
  logic [DATA_W-1:0] w_s0;
  logic [DATA_W-1:0] w_s1;
  logic [DATA_W-1:0] w_result;
  logic              w_writes;
  logic              w_cond;
  logic              w_we;
  logic              w_branch;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [SP_W-1:0]   w_sp_inc;
  logic [SP_W-1:0]   w_sp_dec;
  logic [IP_W-1:0]   w_top;
  logic [IP_W-1:0]   w_target;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_valid  <= 1'b0;
      r_op     <= OP_NOP;
      r_dst    <= '0;
      r_a0     <= '0;
      r_a1     <= '0;
      r_ret_ip <= '0;
    end else begin
      r_valid  <= iValid;
      r_op     <= iOperation;
      r_dst    <= iDestination;
      r_a0     <= iSourceAddr0;
      r_a1     <= iSourceAddr1;
      r_ret_ip <= iReturnIP;
    end
  end

  assign w_active = r_valid && !r_squash;

  // STO's address fields are an immediate, so they must never pick up forwarded data.
  assign w_fwd0 = r_prev_valid && (r_prev_addr == r_a0) && (r_op != OP_STO);
  assign w_fwd1 = r_prev_valid && (r_prev_addr == r_a1) && (r_op != OP_STO);
  assign w_s0   = w_fwd0 ? r_prev_data : iSourceData0_RAM;
  assign w_s1   = w_fwd1 ? r_prev_data : iSourceData1_RAM;

  always_comb begin
    w_result = '0;
    w_writes = 1'b0;
    w_cond   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_result = w_s1 + w_s0;
        w_writes = 1'b1;
      end
      OP_SUB: begin
        w_result = w_s1 - w_s0;
        w_writes = 1'b1;
      end
      OP_AND: begin
        w_result = w_s1 & w_s0;
        w_writes = 1'b1;
      end
      OP_OR: begin
        w_result = w_s1 | w_s0;
        w_writes = 1'b1;
      end
      OP_XOR: begin
        w_result = w_s1 ^ w_s0;
        w_writes = 1'b1;
      end
      OP_STO: begin
        w_result = DATA_W'({r_a1, r_a0});
        w_writes = 1'b1;
      end
      OP_BLE:                   w_cond = (w_s1 <= w_s0);
      OP_JMP, OP_CALL, OP_RET:  w_cond = 1'b1;
      default: begin
        w_result = '0;
        w_writes = 1'b0;
        w_cond   = 1'b0;
      end
    endcase
  end

  assign w_we     = w_active && w_writes;
  assign w_branch = w_active && w_cond;
  assign w_push   = w_active && (r_op == OP_CALL);
  assign w_pop    = w_active && (r_op == OP_RET);

  // Circular return stack: r_sp is the next free slot, the top lives one below it.
  assign w_full   = (r_depth == DEPTH_W'(RAS_DEPTH));
  assign w_empty  = (r_depth == '0);
  assign w_sp_inc = (r_sp == SP_W'(RAS_DEPTH - 1)) ? '0 : r_sp + 1'b1;
  assign w_sp_dec = (r_sp == '0) ? SP_W'(RAS_DEPTH - 1) : r_sp - 1'b1;
  assign w_top    = r_ras[w_sp_dec];

  always_comb begin
    w_target = IP_W'(r_dst);
    if (r_op == OP_RET) begin
      w_target = w_empty ? '0 : w_top;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_squash <= 1'b0;
    end else begin
      r_squash <= w_branch;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_prev_valid <= 1'b0;
      r_prev_addr  <= '0;
      r_prev_data  <= '0;
    end else if (w_we) begin
      r_prev_valid <= 1'b1;
      r_prev_addr  <= r_dst;
      r_prev_data  <= w_result;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
      r_sp    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_push) begin
      r_ras[r_sp] <= r_ret_ip;
      r_sp        <= w_sp_inc;
      if (w_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_depth <= r_depth + 1'b1;
      end
    end else if (w_pop) begin
      if (w_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_sp    <= w_sp_dec;
        r_depth <= r_depth - 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_led <= '0;
    end else if (w_active && (r_op == OP_LED)) begin
      r_led <= w_s1[LED_W-1:0];
    end
  end

  assign oWriteEnable    = w_we;
  assign oWriteAddress   = r_dst;
  assign oWriteData      = w_result;
  assign oBranchTaken    = w_branch;
  assign oBranchTarget   = w_branch ? w_target : '0;
  assign oLed            = r_led;
  assign oStackDepth     = r_depth;
  assign oStackOverflow  = r_ovf;
  assign oStackUnderflow = r_unf;

endmodule

// File: tb/tb_minialu_exec_stage.sv
// Scoreboard bench for minialu_exec_stage: directed instructions push hand-computed
// expectations; a negedge monitor pops and compares them in the execute cycle.
module tb_minialu_exec_stage;

  logic        Clock;
  logic        Reset;
  logic        iValid;
  logic [3:0]  iOperation;
  logic [7:0]  iDestination;
  logic [7:0]  iSourceAddr0;
  logic [7:0]  iSourceAddr1;
  logic [15:0] iReturnIP;
  logic [15:0] iSourceData0_RAM;
  logic [15:0] iSourceData1_RAM;
  logic        oWriteEnable;
  logic [7:0]  oWriteAddress;
  logic [15:0] oWriteData;
  logic        oBranchTaken;
  logic [15:0] oBranchTarget;
  logic [7:0]  oLed;
  logic [2:0]  oStackDepth;
  logic        oStackOverflow;
  logic        oStackUnderflow;

  minialu_exec_stage dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .iOperation(iOperation),
    .iDestination(iDestination), .iSourceAddr0(iSourceAddr0), .iSourceAddr1(iSourceAddr1),
    .iReturnIP(iReturnIP), .iSourceData0_RAM(iSourceData0_RAM),
    .iSourceData1_RAM(iSourceData1_RAM), .oWriteEnable(oWriteEnable),
    .oWriteAddress(oWriteAddress), .oWriteData(oWriteData), .oBranchTaken(oBranchTaken),
    .oBranchTarget(oBranchTarget), .oLed(oLed), .oStackDepth(oStackDepth),
    .oStackOverflow(oStackOverflow), .oStackUnderflow(oStackUnderflow)
  );

  typedef struct {
    int due;
    int we;
    int wa;
    int wd;
    int br;
    int bt;
    int dep;
    int ovf;
    int unf;
    int led;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   pend0 = 0;
  int   pend1 = 0;
  int   e_ovf = 0;
  int   e_unf = 0;
  int   e_led = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Instruction fields go out now; its RAM read data goes out with the next instruction,
  // i.e. during the cycle in which this one executes.
  task automatic issue(input int v, input int op, input int dst, input int a0, input int a1,
                       input int ret, input int r0, input int r1, input int we, input int wa,
                       input int wd, input int br, input int bt, input int dep);
    exp_t e;
    @(negedge Clock);
    iSourceData0_RAM = 16'(pend0);
    iSourceData1_RAM = 16'(pend1);
    iValid       = 1'(v);
    iOperation   = 4'(op);
    iDestination = 8'(dst);
    iSourceAddr0 = 8'(a0);
    iSourceAddr1 = 8'(a1);
    iReturnIP    = 16'(ret);
    pend0 = r0;
    pend1 = r1;
    e.due = cyc + 1;
    e.we  = we;
    e.wa  = wa;
    e.wd  = wd;
    e.br  = br;
    e.bt  = bt;
    e.dep = dep;
    e.ovf = e_ovf;
    e.unf = e_unf;
    e.led = e_led;
    q.push_back(e);
  endtask

  always @(negedge Clock) begin
    #2;
    while (q.size() > 0 && q[0].due == cyc) begin
      m_e = q.pop_front();
      check("write_en", int'(oWriteEnable), m_e.we);
      if (m_e.we != 0) begin
        check("write_addr", int'(oWriteAddress), m_e.wa);
        check("write_data", int'(oWriteData), m_e.wd);
      end
      check("branch_taken", int'(oBranchTaken), m_e.br);
      if (m_e.br != 0) check("branch_target", int'(oBranchTarget), m_e.bt);
      check("stack_depth", int'(oStackDepth), m_e.dep);
      check("overflow", int'(oStackOverflow), m_e.ovf);
      check("underflow", int'(oStackUnderflow), m_e.unf);
      check("led", int'(oLed), m_e.led);
    end
  end

  initial begin
    Reset = 1'b0;
    iValid = 1'b0;
    iOperation = 4'h0;
    iDestination = 8'h0;
    iSourceAddr0 = 8'h0;
    iSourceAddr1 = 8'h0;
    iReturnIP = 16'h0;
    iSourceData0_RAM = 16'h0;
    iSourceData1_RAM = 16'h0;
    repeat (2) @(negedge Clock);
    check("rst_we", int'(oWriteEnable), 0);
    check("rst_branch", int'(oBranchTaken), 0);
    check("rst_led", int'(oLed), 0);
    check("rst_depth", int'(oStackDepth), 0);
    check("rst_ovf", int'(oStackOverflow), 0);
    check("rst_unf", int'(oStackUnderflow), 0);
    Reset = 1'b1;

    //    v  op    dst   a0    a1  ret  ram0    ram1    we wa  wd      br bt    dep
    issue(1, 'hC,  1,    5,    0,  0,   0,      0,      1, 1,  5,      0, 0,    0); // STO r1<-5
    issue(1, 'h1,  2,    1,    1,  0,   0,      0,      1, 2,  10,     0, 0,    0); // ADD fwd
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    0);
    issue(1, 'h1,  3,    1,    2,  0,   5,      10,     1, 3,  15,     0, 0,    0);
    issue(1, 'h2,  4,    6,    5,  0,   1,      0,      1, 4,  'hFFFF, 0, 0,    0); // 0-1 wraps
    issue(1, 'h6,  'h40, 8,    7,  0,   3,      3,      0, 0,  0,      1, 'h40, 0); // BLE 3<=3
    issue(1, 'hC,  9,    'h77, 0,  0,   0,      0,      0, 0,  0,      0, 0,    0); // squashed
    issue(1, 'hC,  9,    'h12, 0,  0,   0,      0,      1, 9,  'h12,   0, 0,    0);
    issue(1, 'h6,  'h50, 'h21, 'h20, 0, 3,      4,      0, 0,  0,      0, 0,    0); // 4<=3 no
    issue(0, 'hC,  9,    7,    0,  0,   0,      0,      0, 0,  0,      0, 0,    0); // not valid
    issue(1, 'h3,  5,    'h31, 'h30, 0, 'h0FF0, 'hF0F0, 1, 5,  'h00F0, 0, 0,    0);
    issue(1, 'h4,  6,    'h31, 'h30, 0, 'h0FF0, 'hF0F0, 1, 6,  'hFFF0, 0, 0,    0);
    issue(1, 'h5,  7,    'h31, 'h30, 0, 'h0FF0, 'hF0F0, 1, 7,  'hFF00, 0, 0,    0);
    issue(1, 'hB,  8,    1,    2,  0,   0,      0,      0, 0,  0,      0, 0,    0); // undefined op
    issue(1, 'hA,  'h33, 0,    0,  0,   0,      0,      0, 0,  0,      1, 'h33, 0); // JMP
    issue(1, 'hC,  8,    1,    0,  0,   0,      0,      0, 0,  0,      0, 0,    0); // squashed
    // nested calls
    issue(1, 'h8,  'h10, 0,    0,  'h11, 0,     0,      0, 0,  0,      1, 'h10, 0);
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    1);
    issue(1, 'h8,  'h20, 0,    0,  'h22, 0,     0,      0, 0,  0,      1, 'h20, 1);
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    2);
    issue(1, 'h8,  'h30, 0,    0,  'h33, 0,     0,      0, 0,  0,      1, 'h30, 2);
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    3);
    issue(1, 'h9,  0,    0,    0,  0,   0,      0,      0, 0,  0,      1, 'h33, 3);
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    2);
    issue(1, 'h9,  0,    0,    0,  0,   0,      0,      0, 0,  0,      1, 'h22, 2);
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    1);
    issue(1, 'h9,  0,    0,    0,  0,   0,      0,      0, 0,  0,      1, 'h11, 1);
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    0);
    // CALL then RET back-to-back: the RET is squashed, the next RET pops
    issue(1, 'h8,  5,    0,    0,  'h99, 0,     0,      0, 0,  0,      1, 5,    0);
    issue(1, 'h9,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    1);
    issue(1, 'h9,  0,    0,    0,  0,   0,      0,      0, 0,  0,      1, 'h99, 1);
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    0);
    // overflow / underflow
    for (int k = 1; k <= 5; k++) begin
      issue(1, 'h8, 'h60, 0, 0, k, 0, 0, 0, 0, 0, 1, 'h60, (k - 1 > 4) ? 4 : k - 1);
      if (k == 5) e_ovf = 1;
      issue(1, 'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k > 4) ? 4 : k);
    end
    for (int k = 5; k >= 2; k--) begin
      issue(1, 'h9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, k, k - 1);
      issue(1, 'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k - 2);
    end
    issue(1, 'h9,  0,    0,    0,  0,   0,      0,      0, 0,  0,      1, 0,    0);
    e_unf = 1;
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    0);
    // LED takes S1 truncated to 8 bits
    issue(1, 'h7,  0,    0,    'h40, 0, 0,      'h01A5, 0, 0,  0,      0, 0,    0);
    e_led = 'hA5;
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    0);
    issue(1, 'h8,  'h70, 0,    0,  'hAA, 0,     0,      0, 0,  0,      1, 'h70, 0);
    issue(1, 'h0,  0,    0,    0,  0,   0,      0,      0, 0,  0,      0, 0,    1);

    // reset in the middle of an executing CALL
    @(negedge Clock);
    iValid = 1'b1;
    iOperation = 4'h8;
    iDestination = 8'h71;
    iReturnIP = 16'hBB;
    @(posedge Clock);
    #2;
    iValid = 1'b0;
    check("mid_call_branch", int'(oBranchTaken), 1);
    check("mid_call_target", int'(oBranchTarget), 'h71);
    check("mid_call_depth", int'(oStackDepth), 1);
    Reset = 1'b0;
    #1;
    check("async_rst_branch", int'(oBranchTaken), 0);
    check("async_rst_depth", int'(oStackDepth), 0);
    check("async_rst_led", int'(oLed), 0);
    check("async_rst_ovf", int'(oStackOverflow), 0);
    check("async_rst_unf", int'(oStackUnderflow), 0);
    check("async_rst_we", int'(oWriteEnable), 0);
    @(posedge Clock);
    #1;
    check("rst_held_depth", int'(oStackDepth), 0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge Clock);
    check("scoreboard_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
